// File: rtl/core_pkg.sv
// Shared rv32 core types: instruction classes, PC select codes, sequencer states, opcodes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

    // Decoder instruction class; 3'd6 and 3'd7 are left unused and treated as illegal.
    typedef enum logic [2:0] {
        INST_R  = 3'd0,
        INST_I  = 3'd1,
        INST_S  = 3'd2,
        INST_SB = 3'd3,
        INST_UJ = 3'd4,
        INST_U  = 3'd5
    } inst_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_sel_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_ERROR     = 3'd7
    } seq_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Any encoding above U has no instruction class behind it.
    function automatic logic inst_illegal(input logic [2:0] t);
        return t > 3'(INST_U);
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Control bundle between the sequencer, decoder/ALU datapath and the memory port.
// Latency: n/a (wires only).
// Backpressure: memory stalls are expressed by withholding mem_ack while mem_req is high.
interface core_sequencer_if #(
    parameter int CNT_W = 32
);
    import core_pkg::*;

    logic             en;
    logic [2:0]       inst_type;
    logic             is_load;
    logic             branch_taken;
    logic             halt_req;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             mem_sel_data;
    logic             ir_en;
    logic             pc_en;
    pc_sel_t          pc_sel;
    logic             rf_we;
    logic             halted;
    logic             err;
    seq_state_t       state_out;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        input  en, inst_type, is_load, branch_taken, halt_req, mem_ack,
        output mem_req, mem_we, mem_sel_data, ir_en, pc_en, pc_sel, rf_we,
               halted, err, state_out, retired_cnt
    );

    modport slave (
        output en, inst_type, is_load, branch_taken, halt_req, mem_ack,
        input  mem_req, mem_we, mem_sel_data, ir_en, pc_en, pc_sel, rf_we,
               halted, err, state_out, retired_cnt
    );

endinterface

// File: rtl/core_sequencer_mem_timeout_counter.sv
// Counts memory wait cycles and flags the cycle in which the count reaches MEM_TIMEOUT.
// Latency: hit is combinational from the registered count and count_en.
// Backpressure: none; clear has priority over count_en.
module mem_timeout_counter #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic count_en,
    output logic hit
);

    logic [TO_W-1:0] cnt_q;

    // Wait-cycle counter, held at zero while no memory access is in progress.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count_en) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    // This wait cycle is the MEM_TIMEOUT-th one without an ack.
    assign hit = count_en && (cnt_q == TO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle rv32 control FSM: fetch, decode, execute, memory, writeback.
// Latency: 4 cycles per non-memory instruction, 5 for load/store, +1 per memory wait cycle.
// Backpressure: stalls in FETCH/MEM until mem_ack; MEM_TIMEOUT wait cycles without ack -> ERROR.
module core_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             nrst,
    core_sequencer_if.master bus
);
    import core_pkg::*;

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] retired_q;
    logic             mem_phase;
    logic             to_hit;
    logic             is_store;
    logic             is_mem_op;

    assign is_store  = (bus.inst_type == 3'(INST_S));
    assign is_mem_op = bus.is_load || is_store;
    assign mem_phase = (state == S_FETCH) || (state == S_MEM);

    // Outside FETCH/MEM the counter sits at zero, so every memory access starts from a clean count.
    mem_timeout_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_timeout (
        .clk      (clk),
        .nrst     (nrst),
        .clear    (!mem_phase),
        .count_en (mem_phase && !bus.mem_ack),
        .hit      (to_hit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Retired-instruction counter, one step per writeback, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            retired_q <= '0;
        end else if (state == S_WRITEBACK) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Next-state and strobe decode; only ir_en and the memory-completion transitions look at mem_ack.
    always_comb begin
        state_nxt        = state;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_sel_data = 1'b0;
        bus.ir_en        = 1'b0;
        bus.pc_en        = 1'b0;
        bus.pc_sel       = PC_PLUS4;
        bus.rf_we        = 1'b0;
        bus.halted       = 1'b0;
        bus.err          = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.en) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.ir_en   = bus.mem_ack;
                if (bus.mem_ack)   state_nxt = S_DECODE;
                else if (to_hit)   state_nxt = S_ERROR;
            end
            S_DECODE: begin
                if (inst_illegal(bus.inst_type)) state_nxt = S_ERROR;
                else if (bus.halt_req)           state_nxt = S_HALT;
                else                             state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_nxt = is_mem_op ? S_MEM : S_WRITEBACK;
            end
            S_MEM: begin
                bus.mem_req      = 1'b1;
                bus.mem_sel_data = 1'b1;
                bus.mem_we       = is_store;
                if (bus.mem_ack)   state_nxt = S_WRITEBACK;
                else if (to_hit)   state_nxt = S_ERROR;
            end
            S_WRITEBACK: begin
                bus.pc_en = 1'b1;
                if ((bus.inst_type == 3'(INST_SB)) && bus.branch_taken) bus.pc_sel = PC_BRANCH;
                else if (bus.inst_type == 3'(INST_UJ))                  bus.pc_sel = PC_JUMP;
                bus.rf_we = !(is_store || (bus.inst_type == 3'(INST_SB)));
                state_nxt = bus.en ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            S_ERROR: begin
                bus.err = 1'b1;
            end
            default: begin
                state_nxt = S_ERROR;
            end
        endcase
    end

    assign bus.state_out   = state;
    assign bus.retired_cnt = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;
    import core_pkg::*;

    logic clk = 1'b0;
    logic nrst;

    core_sequencer_if #(.CNT_W(32)) bus();

    core_sequencer #(
        .MEM_TIMEOUT (4),
        .TO_W        (8),
        .CNT_W       (32)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] pc_sel;
        logic       rf_we;
        int         cycles;
        int         mem_cycles;
    } exp_t;

    typedef struct {
        inst_t t;
        bit    ld;
        bit    taken;
        int    flat;
        int    mlat;
    } stim_t;

    exp_t  exp_q[$];
    stim_t tbl[$];

    int    n_tests = 0;
    int    n_fail  = 0;
    int    fw, mw;
    int    fetch_lat, mem_lat;
    bit    ack_never;
    logic [31:0] model_retired;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic inst_t type_of(input logic [6:0] op);
        case (op)
            OP_LOAD:   return INST_I;
            OP_STORE:  return INST_S;
            OP_BRANCH: return INST_SB;
            OP_JAL:    return INST_UJ;
            default:   return INST_R;
        endcase
    endfunction

    // Memory model: acks after fetch_lat / mem_lat wait cycles; called just after a negedge.
    task automatic mem_cycle();
        logic a;
        a = 1'b0;
        if (bus.mem_req && !ack_never) begin
            if (!bus.mem_sel_data) begin a = (fw >= fetch_lat); fw++; end
            else                   begin a = (mw >= mem_lat);   mw++; end
        end
        if (!bus.mem_req) begin fw = 0; mw = 0; end
        bus.mem_ack = a;
        #1;
    endtask

    task automatic do_reset();
        nrst        = 1'b0;
        bus.mem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        nrst          = 1'b1;
        model_retired = '0;
    endtask

    task automatic run_instr(input stim_t s, input bit drop_en);
        exp_t e;
        bit   mem_op;
        bit   done;
        int   cyc, mcyc;
        mem_op       = s.ld || (s.t == INST_S);
        e.pc_sel     = (s.t == INST_SB && s.taken) ? 2'b01 : (s.t == INST_UJ) ? 2'b10 : 2'b00;
        e.rf_we      = !(s.t == INST_S || s.t == INST_SB);
        e.cycles     = 4 + s.flat + (mem_op ? 1 + s.mlat : 0);
        e.mem_cycles = mem_op ? s.mlat + 1 : 0;
        exp_q.push_back(e);
        bus.inst_type    = s.t;
        bus.is_load      = s.ld;
        bus.branch_taken = s.taken;
        bus.halt_req     = 1'b0;
        fetch_lat        = s.flat;
        mem_lat          = s.mlat;
        cyc = 0; mcyc = 0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            mem_cycle();
            if (bus.state_out != S_IDLE) cyc++;
            if (bus.state_out == S_FETCH) chk("ir_en", bus.ir_en, bus.mem_ack);
            if (bus.mem_req && bus.mem_sel_data) begin
                mcyc++;
                chk("mem_we", bus.mem_we, s.t == INST_S);
            end
            if (drop_en && bus.state_out == S_EXECUTE) bus.en = 1'b0;
            if (bus.pc_en) begin
                e = exp_q.pop_front();
                chk("pc_sel", bus.pc_sel, e.pc_sel);
                chk("rf_we", bus.rf_we, e.rf_we);
                chk("cycles", cyc, e.cycles);
                chk("mem_cycles", mcyc, e.mem_cycles);
                chk("retired", bus.retired_cnt, model_retired);
                model_retired++;
                done = 1;
            end
        end
        if (!done) begin
            chk("wb_seen", 0, 1);
            exp_q.delete();
        end
        @(posedge clk);
    endtask

    task automatic run_to_stop(input logic [2:0] t, input bit hreq, output int cyc);
        bus.inst_type    = t;
        bus.halt_req     = hreq;
        bus.is_load      = 1'b0;
        bus.branch_taken = 1'b0;
        fetch_lat        = 0;
        cyc              = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            mem_cycle();
            if (bus.halted || bus.err) break;
            if (bus.state_out != S_IDLE) cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int cnt;
        bus.en = 1'b0; bus.inst_type = '0; bus.is_load = 1'b0;
        bus.branch_taken = 1'b0; bus.halt_req = 1'b0; bus.mem_ack = 1'b0;
        fw = 0; mw = 0; fetch_lat = 0; mem_lat = 0; ack_never = 0;
        do_reset();

        @(negedge clk);
        chk("rst_state", bus.state_out, S_IDLE);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_strobes", {bus.ir_en, bus.pc_en, bus.rf_we, bus.mem_we}, 0);
        chk("rst_flags", {bus.halted, bus.err}, 0);
        chk("rst_retired", bus.retired_cnt, 0);

        tbl.push_back('{INST_R, 0, 0, 0, 0});
        tbl.push_back('{type_of(OP_STORE), 0, 0, 0, 3});
        tbl.push_back('{type_of(OP_LOAD), 1, 0, 2, 0});
        tbl.push_back('{type_of(OP_BRANCH), 0, 1, 0, 0});
        tbl.push_back('{type_of(OP_BRANCH), 0, 0, 0, 0});
        tbl.push_back('{type_of(OP_JAL), 0, 0, 0, 0});
        tbl.push_back('{INST_U, 0, 0, 1, 0});
        tbl.push_back('{INST_I, 0, 1, 3, 0});
        tbl.push_back('{type_of(OP_LOAD), 1, 0, 0, 3});

        bus.en = 1'b1;
        foreach (tbl[i]) run_instr(tbl[i], 0);

        // en dropped in EXECUTE: instruction still retires, then IDLE.
        run_instr('{INST_R, 0, 0, 0, 0}, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_cycle();
            chk("idle_after_en_drop", bus.state_out, S_IDLE);
            chk("idle_mem_req", bus.mem_req, 0);
        end
        chk("retired_after_drop", bus.retired_cnt, model_retired);

        // Halt: FETCH + DECODE, then sticky HALT without retiring.
        bus.en = 1'b1;
        run_to_stop(3'(INST_R), 1, cyc);
        chk("halt_cycles", cyc, 2);
        chk("halted", bus.halted, 1);
        chk("halt_err", bus.err, 0);
        chk("halt_retired", bus.retired_cnt, model_retired);
        for (int i = 0; i < 4; i++) begin
            bus.en = ~bus.en;
            @(negedge clk);
            chk("halt_sticky", {bus.halted, bus.mem_req, bus.pc_en}, 3'b100);
        end
        bus.halt_req = 1'b0;
        do_reset();
        @(negedge clk);
        chk("halt_cleared", bus.halted, 0);

        // Illegal type wins over halt_req in DECODE.
        bus.en = 1'b1;
        run_to_stop(3'd7, 1, cyc);
        chk("illegal_err", bus.err, 1);
        chk("illegal_not_halted", bus.halted, 0);
        chk("illegal_retired", bus.retired_cnt, 0);
        bus.halt_req = 1'b0;
        do_reset();

        // Fetch timeout: exactly MEM_TIMEOUT request cycles, then ERROR with mem_req low.
        ack_never = 1;
        bus.inst_type = 3'(INST_R);
        bus.en = 1'b1;
        cnt = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            mem_cycle();
            if (bus.err) break;
            if (bus.mem_req) cnt++;
        end
        chk("timeout_req_cycles", cnt, 4);
        chk("timeout_err", bus.err, 1);
        chk("timeout_mem_req", bus.mem_req, 0);
        for (int i = 0; i < 4; i++) begin
            bus.en = ~bus.en;
            @(negedge clk);
            chk("err_sticky", bus.state_out, S_ERROR);
        end
        nrst = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        chk("err_cleared", {bus.err, bus.state_out}, 0);
        ack_never = 0;
        model_retired = '0;

        // Reset during a stalled store in MEM.
        bus.en = 1'b1;
        bus.inst_type = 3'(INST_S);
        bus.is_load = 1'b0;
        fetch_lat = 0;
        mem_lat = 10;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            mem_cycle();
            if (bus.state_out == S_MEM && mw >= 2) break;
        end
        chk("reached_mem", bus.state_out, S_MEM);
        chk("mem_req_before_rst", {bus.mem_req, bus.mem_we}, 2'b11);
        nrst = 1'b0;
        bus.mem_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_state", bus.state_out, S_IDLE);
        chk("rst_mid_outputs", {bus.mem_req, bus.mem_we, bus.mem_sel_data, bus.ir_en,
                                bus.pc_en, bus.pc_sel, bus.rf_we, bus.halted, bus.err}, 0);
        chk("rst_mid_retired", bus.retired_cnt, 0);
        nrst = 1'b1;
        model_retired = '0;

        // Recovery after the abandoned request.
        run_instr('{INST_U, 0, 0, 0, 0}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
